mining_job_dispatcher: RTL and testbench

- Upstream sequencer for multi_supervisor.
- Accepts block-header jobs over a valid/ready handshake into a 2-entry job buffer.
- For each job: pulses the supervisor's reset, holds start until process_complete, captures the result, and presents it on a valid/ready result port.
- Lets software queue the next header while the current one is mined, removing register-poll gaps between jobs.

---
 rtl/mining_job_dispatcher.sv | 241 ++++++++++++++++++++++++
 tb/tb_mining_job_dispatcher.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mining_job_dispatcher.sv
// mining_job_dispatcher: 2-entry header queue that sequences multi_supervisor (reset, start, collect result).
// Optional macro JOB_CYCLE_COUNT_EN adds o_res_cycles, the RUN cycle count of the reported job.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | queue empty, supervisor held in reset
// S_RST    | supervisor reset held for RESET_CYCLES before the head job
// S_RUN    | supervisor mining the head job, waiting for complete/abort/timeout
// S_REPORT | result presented, head popped on result handshake
module mining_job_dispatcher #(
    parameter int unsigned RESET_CYCLES   = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_job_valid,
    output logic         o_job_ready,
    input  logic [31:0]  i_job_version,
    input  logic [255:0] i_job_prev_hash,
    input  logic [255:0] i_job_merkle,
    input  logic [31:0]  i_job_timestamp,
    input  logic [31:0]  i_job_bits,
    input  logic [31:0]  i_job_target,
    input  logic         i_abort,
    output logic         o_sup_reset,
    output logic         o_sup_start,
    output logic [31:0]  o_sup_version,
    output logic [255:0] o_sup_prev_hash,
    output logic [255:0] o_sup_merkle,
    output logic [31:0]  o_sup_timestamp,
    output logic [31:0]  o_sup_bits,
    output logic [31:0]  o_sup_target,
    input  logic         i_sup_process_complete,
    input  logic         i_sup_success,
    input  logic [255:0] i_sup_hash,
    input  logic [31:0]  i_sup_nonce,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [7:0]   o_res_job_id,
    output logic         o_res_success,
    output logic         o_res_timeout,
    output logic [31:0]  o_res_nonce,
    output logic [255:0] o_res_hash,
    output logic         o_busy
`ifdef JOB_CYCLE_COUNT_EN
    ,
    output logic [31:0]  o_res_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_REPORT} state_t;

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

`ifdef JOB_CYCLE_COUNT_EN
    localparam bit RUN_CNT_EN = 1'b1;
`else
    localparam bit RUN_CNT_EN = (TIMEOUT_CYCLES != 32'd0);
`endif

    state_t          r_state, w_state_nxt;
    logic [RC_W-1:0] r_rst_cnt;
    logic [31:0]     w_run_cnt;
    logic [31:0]     w_run_cnt_inc;

    logic [31:0]     r_ver  [2];
    logic [255:0]    r_prev [2];
    logic [255:0]    r_merk [2];
    logic [31:0]     r_ts   [2];
    logic [31:0]     r_bits [2];
    logic [31:0]     r_tgt  [2];
    logic [7:0]      r_id   [2];
    logic            r_wptr, r_rptr;
    logic [1:0]      r_count;
    logic [1:0]      w_count_nxt;
    logic [7:0]      r_next_id;

    logic            w_push, w_pop;
    logic            w_capture, w_cap_fail, w_timeout_hit;

    logic            r_res_success, r_res_timeout;
    logic [31:0]     r_res_nonce;
    logic [255:0]    r_res_hash;
    logic [7:0]      r_res_job_id;

    assign o_job_ready = (r_count != 2'd2);
    assign w_push      = i_job_valid && o_job_ready;
    assign w_pop       = (r_state == S_REPORT) && i_res_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_next_id <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                r_ver[i]  <= '0;
                r_prev[i] <= '0;
                r_merk[i] <= '0;
                r_ts[i]   <= '0;
                r_bits[i] <= '0;
                r_tgt[i]  <= '0;
                r_id[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_ver[r_wptr]  <= i_job_version;
                r_prev[r_wptr] <= i_job_prev_hash;
                r_merk[r_wptr] <= i_job_merkle;
                r_ts[r_wptr]   <= i_job_timestamp;
                r_bits[r_wptr] <= i_job_bits;
                r_tgt[r_wptr]  <= i_job_target;
                r_id[r_wptr]   <= r_next_id;
                r_wptr         <= ~r_wptr;
                r_next_id      <= r_next_id + 8'd1;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // Header fields come from stored entries only; the head moves on pop.
    assign o_sup_version   = r_ver[r_rptr];
    assign o_sup_prev_hash = r_prev[r_rptr];
    assign o_sup_merkle    = r_merk[r_rptr];
    assign o_sup_timestamp = r_ts[r_rptr];
    assign o_sup_bits      = r_bits[r_rptr];
    assign o_sup_target    = r_tgt[r_rptr];

    generate
        if (RUN_CNT_EN) begin : g_run_cnt
            logic [31:0] r_run_cnt;
            always_ff @(posedge clk) begin
                if (reset || (r_state != S_RUN)) begin
                    r_run_cnt <= '0;
                end else if (r_run_cnt != 32'hFFFF_FFFF) begin
                    r_run_cnt <= r_run_cnt + 32'd1;
                end
            end
            assign w_run_cnt = r_run_cnt;
        end else begin : g_no_run_cnt
            assign w_run_cnt = '0;
        end
    endgenerate

    assign w_run_cnt_inc = (w_run_cnt == 32'hFFFF_FFFF) ? w_run_cnt : (w_run_cnt + 32'd1);
    assign w_timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (w_run_cnt == (TIMEOUT_CYCLES - 32'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt == S_RST) && (r_state != S_RST)) begin
                r_rst_cnt <= RC_LOAD;
            end else if ((r_state == S_RST) && (r_rst_cnt != '0)) begin
                r_rst_cnt <= r_rst_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cap_fail  = 1'b0;
        o_sup_reset = 1'b1;
        o_sup_start = 1'b0;
        o_res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != 2'd0) w_state_nxt = S_RST;
            end
            S_RST: begin
                if (r_rst_cnt == '0) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                o_sup_reset = 1'b0;
                o_sup_start = 1'b1;
                if (i_abort || (!i_sup_process_complete && w_timeout_hit)) begin
                    w_state_nxt = S_REPORT;
                    w_capture   = 1'b1;
                    w_cap_fail  = 1'b1;
                end else if (i_sup_process_complete) begin
                    w_state_nxt = S_REPORT;
                    w_capture   = 1'b1;
                end
            end
            S_REPORT: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    w_state_nxt = (w_count_nxt != 2'd0) ? S_RST : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_success <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_nonce   <= '0;
            r_res_hash    <= '0;
            r_res_job_id  <= '0;
        end else if (w_capture) begin
            r_res_success <= !w_cap_fail && i_sup_success;
            r_res_timeout <= w_cap_fail;
            r_res_nonce   <= i_sup_nonce;
            r_res_hash    <= (!w_cap_fail && i_sup_success) ? i_sup_hash : '0;
            r_res_job_id  <= r_id[r_rptr];
        end
    end

`ifdef JOB_CYCLE_COUNT_EN
    logic [31:0] r_res_cycles;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_cycles <= '0;
        end else if (w_capture) begin
            r_res_cycles <= w_run_cnt_inc;
        end
    end
    assign o_res_cycles = r_res_cycles;
`else
    logic w_unused;
    assign w_unused = ^w_run_cnt_inc;
`endif

    assign o_res_success = r_res_success;
    assign o_res_timeout = r_res_timeout;
    assign o_res_nonce   = r_res_nonce;
    assign o_res_hash    = r_res_hash;
    assign o_res_job_id  = r_res_job_id;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mining_job_dispatcher.sv
// Scoreboard bench for mining_job_dispatcher with a small behavioural supervisor model.
module tb_mining_job_dispatcher;

    localparam logic [255:0] HASH_C = {8{32'hDEAD_BEEF}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [31:0]  job_version = '0;
    logic [255:0] job_prev_hash = '0;
    logic [255:0] job_merkle = '0;
    logic [31:0]  job_timestamp = '0;
    logic [31:0]  job_bits = '0;
    logic [31:0]  job_target = '0;
    logic         abort = 1'b0;
    logic         sup_reset, sup_start;
    logic [31:0]  sup_version, sup_timestamp, sup_bits, sup_target;
    logic [255:0] sup_prev_hash, sup_merkle;
    logic         sup_process_complete = 1'b0;
    logic         sup_success = 1'b0;
    logic [255:0] sup_hash = HASH_C;
    logic [31:0]  sup_nonce = '0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [7:0]   res_job_id;
    logic         res_success, res_timeout;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;
    logic         busy;
`ifdef JOB_CYCLE_COUNT_EN
    logic [31:0]  res_cycles;
`endif

    mining_job_dispatcher #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .reset(reset),
        .i_job_valid(job_valid), .o_job_ready(job_ready),
        .i_job_version(job_version), .i_job_prev_hash(job_prev_hash),
        .i_job_merkle(job_merkle), .i_job_timestamp(job_timestamp),
        .i_job_bits(job_bits), .i_job_target(job_target),
        .i_abort(abort),
        .o_sup_reset(sup_reset), .o_sup_start(sup_start),
        .o_sup_version(sup_version), .o_sup_prev_hash(sup_prev_hash),
        .o_sup_merkle(sup_merkle), .o_sup_timestamp(sup_timestamp),
        .o_sup_bits(sup_bits), .o_sup_target(sup_target),
        .i_sup_process_complete(sup_process_complete), .i_sup_success(sup_success),
        .i_sup_hash(sup_hash), .i_sup_nonce(sup_nonce),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_job_id(res_job_id), .o_res_success(res_success),
        .o_res_timeout(res_timeout), .o_res_nonce(res_nonce),
        .o_res_hash(res_hash), .o_busy(busy)
`ifdef JOB_CYCLE_COUNT_EN
        , .o_res_cycles(res_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   id;
        logic         success;
        logic         timeout;
        logic [31:0]  nonce;
        logic [255:0] hash;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_results = 0;
    int   next_id = 0;

    // supervisor model configuration
    logic        cfg_complete = 1'b0;
    int          cfg_delay = 0;
    logic        cfg_succ = 1'b0;
    logic [31:0] cfg_nonce = '0;
    int          run_ctr = 0;
    int          rst_run = 0;
    logic        prev_start = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Supervisor: while started, nonce tracks the RUN cycle; completes after cfg_delay cycles.
    always @(negedge clk) begin
        if (reset || !sup_start) begin
            run_ctr = 0;
            sup_process_complete = 1'b0;
            sup_success = 1'b0;
            sup_nonce = '0;
        end else begin
            run_ctr++;
            if (cfg_complete && run_ctr == cfg_delay) begin
                sup_process_complete = 1'b1;
                sup_success = cfg_succ;
                sup_nonce = cfg_nonce + sup_version;
            end else if (!sup_process_complete) begin
                sup_nonce = run_ctr;
            end
        end
    end

    // Monitor: result scoreboard plus RST-length check on every job start.
    always @(negedge clk) begin
        if (reset || !busy) begin
            rst_run = 0;
        end else if (sup_reset && !res_valid) begin
            rst_run++;
        end
        if (!reset && sup_start && !prev_start) begin
            check("rst_cycles", rst_run, 2);
            rst_run = 0;
        end
        prev_start = sup_start;
        if (!reset && res_valid && res_ready) begin
            check("rep_sup_start", sup_start, 1'b0);
            check("rep_sup_reset", sup_reset, 1'b1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got id %0d want none", res_job_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_job_id", res_job_id, e.id);
                check("res_success", res_success, e.success);
                check("res_timeout", res_timeout, e.timeout);
                check("res_nonce", res_nonce, e.nonce);
                check("res_hash", res_hash, e.hash);
            end
            n_results++;
        end
    end

    task automatic expect_res(input logic s, input logic t, input logic [31:0] n, input logic [255:0] h);
        exp_t e;
        e.id = 8'(next_id);
        e.success = s;
        e.timeout = t;
        e.nonce = n;
        e.hash = h;
        exp_q.push_back(e);
    endtask

    task automatic push_job(input logic [31:0] ver, input logic [31:0] tgt);
        int w = 0;
        while (!job_ready && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        check("push_ready", job_ready, 1'b1);
        job_version = ver;
        job_target = tgt;
        job_timestamp = ver + 32'h6000_0000;
        job_bits = 32'h1703_0000 | ver;
        job_prev_hash = {8{ver}};
        job_merkle = ~{8{ver}};
        job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        next_id++;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || busy) && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_done", (exp_q.size() == 0) && !busy, 1'b1);
    endtask

    task automatic wait_start();
        int w = 0;
        while (!sup_start && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("wait_start", sup_start, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        next_id = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sup_reset", sup_reset, 1'b1);
        check("rst_sup_start", sup_start, 1'b0);
        check("rst_res_fields", {res_success, res_timeout, res_nonce, res_job_id}, '0);
        check("rst_res_hash", res_hash, '0);
        check("rst_sup_fields", {sup_version, sup_target, sup_bits, sup_timestamp}, '0);
        check("rst_sup_prev", sup_prev_hash ^ sup_merkle, '0);

        // single job, success after 50 RUN cycles
        cfg_complete = 1'b1; cfg_delay = 50; cfg_succ = 1'b1; cfg_nonce = 32'h0000_1234;
        expect_res(1'b1, 1'b0, 32'h0000_1234, HASH_C);
        push_job(32'h0, 32'd8);
        @(posedge clk); #1; check("lat_start_1", sup_start, 1'b0);
        @(posedge clk); #1; check("lat_start_2", sup_start, 1'b0);
        @(posedge clk); #1; check("lat_start_3", sup_start, 1'b1);
        check("sup_target", sup_target, 32'd8);
        check("sup_reset_run", sup_reset, 1'b0);
        drain();

        // three jobs back-to-back, ids in order, head advances with pops
        do_reset();
        cfg_complete = 1'b1; cfg_delay = 5; cfg_succ = 1'b1; cfg_nonce = 32'h0000_0100;
        expect_res(1'b1, 1'b0, 32'h0000_0110, HASH_C);
        push_job(32'h10, 32'd4);
        expect_res(1'b1, 1'b0, 32'h0000_0120, HASH_C);
        push_job(32'h20, 32'd4);
        check("full_ready_low", job_ready, 1'b0);
        base = n_results;
        expect_res(1'b1, 1'b0, 32'h0000_0130, HASH_C);
        push_job(32'h30, 32'd4);
        check("third_after_pop", n_results > base, 1'b1);
        drain();

        // timeout after 100 RUN cycles; last nonce is the model's cycle count
        do_reset();
        cfg_complete = 1'b0;
        expect_res(1'b0, 1'b1, 32'd100, '0);
        push_job(32'h1, 32'd20);
        drain();

        // abort at RUN cycle 10 with result held; queued job must not start
        do_reset();
        cfg_complete = 1'b0;
        res_ready = 1'b0;
        expect_res(1'b0, 1'b1, 32'd10, '0);
        push_job(32'h2, 32'd20);
        wait_start();
        repeat (9) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_report", res_valid, 1'b1);
        check("abort_timeout", res_timeout, 1'b1);
        expect_res(1'b0, 1'b1, 32'd100, '0);
        push_job(32'h3, 32'd20);
        for (int i = 0; i < 20; i++) begin
            check("hold_valid", res_valid, 1'b1);
            check("hold_nonce", res_nonce, 32'd10);
            check("hold_id", res_job_id, 8'd0);
            check("hold_no_start", sup_start, 1'b0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        drain();

        // supervisor exhausts nonce space without success
        do_reset();
        cfg_complete = 1'b1; cfg_delay = 20; cfg_succ = 1'b0; cfg_nonce = 32'h7FFF_FFFF;
        expect_res(1'b0, 1'b0, 32'h7FFF_FFFF, '0);
        push_job(32'h0, 32'd30);
        drain();

        // reset during RUN with two jobs queued
        do_reset();
        cfg_complete = 1'b0;
        push_job(32'h4, 32'd8);
        push_job(32'h5, 32'd8);
        wait_start();
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        exp_q.delete();
        next_id = 0;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", job_ready, 1'b1);
        check("mid_rst_valid", res_valid, 1'b0);
        check("mid_rst_sup_reset", sup_reset, 1'b1);
        check("mid_rst_sup_start", sup_start, 1'b0);
        reset = 1'b0;
        cfg_complete = 1'b1; cfg_delay = 5; cfg_succ = 1'b1; cfg_nonce = 32'h0000_0055;
        expect_res(1'b1, 1'b0, 32'h0000_0055, HASH_C);
        push_job(32'h0, 32'd8);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
